lcd_rd: RTL and testbench

//   HD44780 4-bit read engine: counterpart of the LCD write path on the same 6-wire bus
//   {en_lcd, rs_lcd, rw_lcd, d[3:0]}. Performs one read cycle (RS=0: busy flag+address

---
 rtl/lcd_rd.sv | 112 +++++++++++
 tb/tb_lcd_rd.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rd.sv
// HD44780 4-bit read engine: one two-nibble read cycle on the shared LCD bus,
// or repeated busy-flag reads until BF clears or MAX_POLL reads are exhausted.
module lcd_rd #(
    parameter int CLK_DIV  = 50,
    parameter int MAX_POLL = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       timeout,
    output logic       en_lcd,
    output logic       rs_lcd,
    output logic       rw_lcd,
    input  logic [3:0] lcd_d_i
);

    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE, SETUP, E1H, E1L, E2H, E2L, DONE
    } state_t;

    state_t        state, next_state;
    logic [DW-1:0] div;
    logic [7:0]    poll_cnt;
    logic          rs_q, poll_q;
    logic [3:0]    hi_q, lo_q;
    logic          phase_last, repoll;

    assign phase_last = (div == DW'(CLK_DIV - 1));
    // Another BF read is needed only while the flag is still set and budget remains
    assign repoll     = poll_q && hi_q[3] && (poll_cnt < 8'(MAX_POLL));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            poll_cnt <= '0;
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            rd_data  <= '0;
            timeout  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE || state == DONE || next_state != state)
                div <= '0;
            else
                div <= div + 1'b1;
            case (state)
                IDLE: if (req) begin
                    rs_q     <= rs_sel & ~poll;
                    poll_q   <= poll;
                    poll_cnt <= 8'd1;
                end
                E1H: if (phase_last) hi_q <= lcd_d_i;
                E2H: if (phase_last) lo_q <= lcd_d_i;
                E2L: if (phase_last) begin
                    if (repoll) begin
                        poll_cnt <= poll_cnt + 8'd1;
                    end else begin
                        rd_data <= {hi_q, lo_q};
                        timeout <= poll_q && hi_q[3];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = SETUP;
            SETUP:   if (phase_last) next_state = E1H;
            E1H:     if (phase_last) next_state = E1L;
            E1L:     if (phase_last) next_state = E2H;
            E2H:     if (phase_last) next_state = E2L;
            E2L:     if (phase_last) next_state = repoll ? SETUP : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        done   = 1'b0;
        en_lcd = 1'b0;
        rw_lcd = 1'b0;
        rs_lcd = 1'b0;
        case (state)
            SETUP, E1L, E2L: begin
                rw_lcd = 1'b1;
                rs_lcd = rs_q;
            end
            E1H, E2H: begin
                rw_lcd = 1'b1;
                rs_lcd = rs_q;
                en_lcd = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_rd.sv
// Directed bench for lcd_rd with CLK_DIV=4, MAX_POLL=3; cycle k after accept is
// observed #1 after the k-th rising edge following the cycle in which req was sampled.
module tb_lcd_rd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       rs_sel = 1'b0;
    logic       poll = 1'b0;
    logic       busy, done, timeout, en_lcd, rs_lcd, rw_lcd;
    logic [7:0] rd_data;
    logic [3:0] lcd_d_i = 4'h0;

    int vectors = 0;
    int miscompares = 0;

    lcd_rd #(.CLK_DIV(4), .MAX_POLL(3)) dut (
        .clk(clk), .reset(reset), .req(req), .rs_sel(rs_sel), .poll(poll),
        .busy(busy), .done(done), .rd_data(rd_data), .timeout(timeout),
        .en_lcd(en_lcd), .rs_lcd(rs_lcd), .rw_lcd(rw_lcd), .lcd_d_i(lcd_d_i)
    );

    always #5 clk = ~clk;

    // Bus rules: enable only during reads, RS steady across an enable pulse
    logic prev_en = 1'b0;
    logic prev_rs = 1'b0;
    always @(negedge clk) begin
        if (!reset && en_lcd) begin
            vectors++;
            if (!rw_lcd) begin
                miscompares++;
                $display("FAIL bus_en_rw: en_lcd=1 with rw_lcd=%0b, need 1", rw_lcd);
            end
            if (prev_en && rs_lcd !== prev_rs) begin
                miscompares++;
                $display("FAIL bus_rs_stable: rs_lcd=%0b, was %0b", rs_lcd, prev_rs);
            end
        end
        prev_en = en_lcd;
        prev_rs = rs_lcd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        vectors++;
        if ({busy, done, en_lcd, rw_lcd, rs_lcd, timeout} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, need 000000",
                     {busy, done, en_lcd, rw_lcd, rs_lcd, timeout});
        end
        vectors++;
        if (rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rd_data: got %h, need 00", rd_data);
        end
    endtask

    task automatic test_single_read();
        int done_cnt = 0;
        int done_at = 0;
        logic [7:0] rd_seen = '0;
        logic to_seen = 1'b1;
        step();
        req = 1'b1; rs_sel = 1'b1; poll = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 1) begin req = 1'b0; rs_sel = 1'b0; end
            lcd_d_i = (k <= 10) ? 4'hA : 4'h5;
            vectors++;
            if (en_lcd !== ((k >= 5 && k <= 8) || (k >= 13 && k <= 16))) begin
                miscompares++;
                $display("FAIL single_en k=%0d: got %0b", k, en_lcd);
            end
            vectors++;
            if (rs_lcd !== (k <= 20)) begin
                miscompares++;
                $display("FAIL single_rs k=%0d: got %0b, need %0b", k, rs_lcd, k <= 20);
            end
            if (k == 22) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_busy_fall: got %0b, need 0", busy);
                end
            end
            if (done) begin
                done_cnt++; done_at = k; rd_seen = rd_data; to_seen = timeout;
            end
        end
        vectors++;
        if (done_cnt !== 1 || done_at !== 21) begin
            miscompares++;
            $display("FAIL single_done: count=%0d at=%0d, need 1 at 21", done_cnt, done_at);
        end
        vectors++;
        if (rd_seen !== 8'hA5 || to_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL single_data: rd=%h to=%0b, need A5 0", rd_seen, to_seen);
        end
        vectors++;
        if (rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_hold: rd=%h, need A5", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        step();
        req = 1'b1; rs_sel = 1'b1; poll = 1'b0; lcd_d_i = 4'h7;
        for (int k = 1; k <= 6; k++) begin
            step();
            req = 1'b0;
        end
        vectors++;
        if (en_lcd !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre_en: got %0b, need 1", en_lcd);
        end
        reset = 1'b1;
        step();
        vectors++;
        if (en_lcd !== 1'b0 || rw_lcd !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_en_off: en=%0b rw=%0b, need 0 0", en_lcd, rw_lcd);
        end
        step();
        step();
        reset = 1'b0;
        vectors++;
        if ({busy, done, en_lcd, rw_lcd} !== 4'b0 || rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_state: ctrl=%b rd=%h, need 0000 00",
                     {busy, done, en_lcd, rw_lcd}, rd_data);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            if (done) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got %0d dones, need 0", done_cnt);
        end
    endtask

    task automatic run_poll(input string name, input logic [3:0] h1, input logic [3:0] h2,
                            input logic [3:0] h3, input logic [3:0] lo,
                            input logic [7:0] exp_rd, input logic exp_to);
        int done_cnt = 0;
        int done_at = 0;
        int rs_bad = 0;
        logic [7:0] rd_seen = '0;
        logic to_seen = 1'b0;
        logic [3:0] hi;
        step();
        req = 1'b1; rs_sel = 1'b1; poll = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            int r;
            int off;
            step();
            if (k == 1) begin req = 1'b0; poll = 1'b0; end
            r   = (k - 1) / 20;
            off = (k - 1) % 20 + 1;
            hi  = (r == 0) ? h1 : (r == 1) ? h2 : h3;
            lcd_d_i = (off <= 10) ? hi : lo;
            if (rs_lcd !== 1'b0) rs_bad++;
            if (k == 21) begin
                vectors++;
                if (rw_lcd !== 1'b1 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_reread: rw=%0b done=%0b, need 1 0", name, rw_lcd, done);
                end
            end
            if (done) begin
                done_cnt++; done_at = k; rd_seen = rd_data; to_seen = timeout;
            end
        end
        vectors++;
        if (rs_bad !== 0) begin
            miscompares++;
            $display("FAIL %s_rs_low: rs_lcd high in %0d cycles, need 0", name, rs_bad);
        end
        vectors++;
        if (done_cnt !== 1 || done_at !== 61) begin
            miscompares++;
            $display("FAIL %s_done: count=%0d at=%0d, need 1 at 61", name, done_cnt, done_at);
        end
        vectors++;
        if (rd_seen !== exp_rd || to_seen !== exp_to) begin
            miscompares++;
            $display("FAIL %s_data: rd=%h to=%0b, need %h %0b", name, rd_seen, to_seen,
                     exp_rd, exp_to);
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt = 0;
        int done_at[2] = '{0, 0};
        logic [7:0] rd_seen = '0;
        step();
        req = 1'b1; rs_sel = 1'b0; poll = 1'b0; lcd_d_i = 4'h6;
        for (int k = 1; k <= 30; k++) begin
            step();
            req = (k == 7);
            if (done) begin done_cnt++; done_at[0] = k; rd_seen = rd_data; end
        end
        vectors++;
        if (done_cnt !== 1 || done_at[0] !== 21 || rd_seen !== 8'h66) begin
            miscompares++;
            $display("FAIL busy_one_done: count=%0d at=%0d rd=%h, need 1 at 21 66",
                     done_cnt, done_at[0], rd_seen);
        end
        done_cnt = 0;
        step();
        req = 1'b1; lcd_d_i = 4'h9;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 23) req = 1'b0;
            if (k == 22 || k == 23) begin
                vectors++;
                if (busy !== (k == 23)) begin
                    miscompares++;
                    $display("FAIL held_busy k=%0d: got %0b, need %0b", k, busy, k == 23);
                end
            end
            if (done) begin
                if (done_cnt < 2) done_at[done_cnt] = k;
                done_cnt++;
                rd_seen = rd_data;
            end
        end
        vectors++;
        if (done_cnt !== 2 || done_at[0] !== 21 || done_at[1] !== 43) begin
            miscompares++;
            $display("FAIL held_req_done: count=%0d at=%0d,%0d, need 2 at 21,43",
                     done_cnt, done_at[0], done_at[1]);
        end
        vectors++;
        if (rd_seen !== 8'h99) begin
            miscompares++;
            $display("FAIL held_req_data: rd=%h, need 99", rd_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reset_mid();
        run_poll("poll_clear", 4'h8, 4'h8, 4'h3, 4'h2, 8'h32, 1'b0);
        run_poll("poll_timeout", 4'hF, 4'hF, 4'hF, 4'hF, 8'hFF, 1'b1);
        test_busy_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
